uart_dev_bridge: RTL and testbench
==================================

Name: uart_dev_bridge

Overview:
- Debug/loader bus master. Parses byte commands from the async_receiver output stream and issues 32-bit read/write transactions on the device bus toward devctrl, using the same handshake the CPU drives.
- Replies to the host through async_transmitter.
- Sits beside cpu; a top-level mux selects the bridge's bus signals while busGrant_i is high.

Parameters:
- TIMEOUT_CYCLES, 2500000, max clk25 cycles between bytes of one command before abort (100 ms at 25 MHz).
- ACK_BYTE, 8'h4B, reply to a completed write ('K').
- NAK_BYTE, 8'h3F, reply to an unknown opcode ('?').

Ports:
- clk25 in 1: system clock, 25 MHz.
- rst in 1: synchronous, active-high reset.
- rxdReady_i in 1: one-cycle pulse, received byte valid.
- rxdData_i in 8: received byte.
- txdBusy_i in 1: transmitter busy.
- txdStart_o out 1: one-cycle pulse, start sending txdData_o.
- txdData_o out 8: byte to send.
- busReq_o out 1: request ownership of the device bus.
- busGrant_i in 1: ownership granted; bridge outputs are selected.
- devEnable_o out 1: transaction active.
- devWrite_o out 1: 1 = write, 0 = read.
- devBusy_i in 1: slave not yet done.
- devPhysicalAddr_o out 32: transaction address.
- devDataSave_o out 32: write data.
- devDataLoad_i in 32: read data.
- devByteSelect_o out 4: byte lanes.
- active_o out 1: high whenever state != IDLE (LED hook).

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers cleared. Reset mid-operation aborts immediately; no reply is sent.
- Host protocol, multi-byte fields little-endian:
  - 0x57 'W' + addr[4] + data[4] -> 32-bit write, reply ACK_BYTE.
  - 0x52 'R' + addr[4] -> 32-bit read, reply data[4].
  - Any other opcode -> reply NAK_BYTE, return to IDLE.
- States: IDLE, GET_ADDR, GET_DATA, REQ, XFER, TX_LOAD, TX_START, TX_WAIT.
- IDLE:
  - rxdReady_i with opcode W or R -> latch opcode, clear byte counter, go to GET_ADDR.
  - Unknown opcode -> queue NAK_BYTE (reply length 1), go to TX_LOAD.
- GET_ADDR / GET_DATA:
  - Each rxdReady_i shifts the byte into bits [31:24] of a right-shifting register and increments a 2-bit counter.
  - After the 4th byte: GET_ADDR -> GET_DATA (W) or REQ (R); GET_DATA -> REQ.
- Inter-byte timeout:
  - Counter is cleared on IDLE and on every accepted byte; it counts in GET_ADDR/GET_DATA.
  - Reaching TIMEOUT_CYCLES -> IDLE, no reply.
- rxdReady_i outside IDLE/GET_ADDR/GET_DATA is dropped.
- REQ: busReq_o=1; wait for busGrant_i, then go to XFER.
- XFER:
  - Drive devEnable_o=1, devByteSelect_o=4'hF, devWrite_o=(opcode==W), address, data. All bus outputs are registered, so they are stable from the first XFER cycle.
  - The transaction completes in the first XFER cycle with devBusy_i==0 (minimum latency 1 cycle).
  - On completion for a read, capture devDataLoad_i.
  - Next cycle: devEnable_o=0, devWrite_o=0, busReq_o=0, then go to TX_LOAD.
  - busGrant_i dropping during XFER is a top-level error; the bridge keeps driving and does not check it.
- Reply:
  - 1 byte for ACK/NAK, 4 bytes LSB-first for a read.
  - TX_LOAD: wait for txdBusy_i==0, set txdData_o, go to TX_START.
  - TX_START: txdStart_o=1 for exactly one cycle, go to TX_WAIT.
  - TX_WAIT: wait one cycle, then wait for txdBusy_i==0; decrement the remaining count; go to TX_LOAD if more bytes remain, else IDLE.
- Simultaneous rxdReady_i and timeout expiry in the same cycle: the byte wins and the timeout counter is cleared.

Decomposition:
- Shared package/header holds:
  - opcode constants CMD_WRITE=8'h57, CMD_READ=8'h52;
  - state encodings;
  - BYTE_SEL_WORD=4'hF.
- One natural sub-module: uart_tx_sequencer. It takes a 32-bit word plus a length (1 or 4), and produces the txdStart_o/txdData_o handshake and a done pulse.

Test Plan:
- Write: send 57 00 00 00 80 EF BE AD DE, grant immediately, devBusy_i low -> one XFER cycle with addr=0x80000000, data=0xDEADBEEF, devWrite_o=1, byteSel=F; txd emits 0x4B.
- Read: send 52 04 00 00 80, devBusy_i high for 3 cycles, devDataLoad_i=0x12345678 -> devEnable_o high for exactly 4 cycles; txd emits 78 56 34 12 in order, one txdStart_o per byte.
- Grant delay: hold busGrant_i low for 50 cycles after addr complete -> devEnable_o stays 0 and busReq_o stays 1 until the grant, then the transaction proceeds normally.
- Bad opcode: send 0x41 -> txd emits 0x3F, no bus activity, the next valid command works.
- Timeout: TIMEOUT_CYCLES=100; send 57 00 00, then 101 idle cycles, then a fresh 52 00 00 00 80 -> first command aborted silently, read at 0x80000000 executes.
- Reset mid-read at XFER: all outputs 0 in the cycle after rst, state IDLE, no txdStart_o.

Source files
------------

// File: rtl/uart_dev_bridge_pkg.sv
// Shared constants and state encoding for the UART debug/loader bus bridge.
// Imported by the bridge top and its reply sequencer.
package uart_dev_bridge_pkg;

    localparam logic [7:0] CMD_WRITE     = 8'h57;
    localparam logic [7:0] CMD_READ      = 8'h52;
    localparam logic [3:0] BYTE_SEL_WORD = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        REQ,
        XFER,
        TX_LOAD,
        TX_START,
        TX_WAIT
    } state_t;

endpackage

// File: rtl/uart_tx_sequencer.sv
// Sends a 1- or 4-byte reply (LSB first) through the async_transmitter handshake,
// pulsing done once the last byte has left the transmitter.
module uart_tx_sequencer
    import uart_dev_bridge_pkg::*;
(
    input  logic        clk25,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] word,
    input  logic        wide,
    input  logic        txd_busy,
    output logic        txd_start,
    output logic [7:0]  txd_data,
    output logic        done
);

    state_t      state, state_next;
    logic [31:0] shift, shift_next;
    logic [1:0]  remaining, remaining_next;
    logic        waited, waited_next;
    logic        txd_start_next;
    logic [7:0]  txd_data_next;

    always_ff @(posedge clk25) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            remaining <= '0;
            waited    <= 1'b0;
            txd_start <= 1'b0;
            txd_data  <= '0;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            remaining <= remaining_next;
            waited    <= waited_next;
            txd_start <= txd_start_next;
            txd_data  <= txd_data_next;
        end
    end

    always_comb begin
        state_next     = state;
        shift_next     = shift;
        remaining_next = remaining;
        waited_next    = waited;
        txd_start_next = 1'b0;
        txd_data_next  = txd_data;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    shift_next     = word;
                    remaining_next = wide ? 2'd3 : 2'd0;
                    state_next     = TX_LOAD;
                end
            end
            TX_LOAD: begin
                // Start is registered alongside the data so both are valid in TX_START.
                if (!txd_busy) begin
                    txd_data_next  = shift[7:0];
                    txd_start_next = 1'b1;
                    state_next     = TX_START;
                end
            end
            TX_START: begin
                waited_next = 1'b0;
                state_next  = TX_WAIT;
            end
            TX_WAIT: begin
                if (!waited) begin
                    waited_next = 1'b1;
                end else if (!txd_busy) begin
                    if (remaining == 2'd0) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        remaining_next = remaining - 2'd1;
                        shift_next     = {8'h00, shift[31:8]};
                        state_next     = TX_LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_dev_bridge.sv
// UART-driven device bus master: parses W/R commands from the receiver stream,
// runs one 32-bit transaction per command and replies through the transmitter.
module uart_dev_bridge
    import uart_dev_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o,
    output logic        busReq_o,
    input  logic        busGrant_i,
    output logic        devEnable_o,
    output logic        devWrite_o,
    input  logic        devBusy_i,
    output logic [31:0] devPhysicalAddr_o,
    output logic [31:0] devDataSave_o,
    input  logic [31:0] devDataLoad_i,
    output logic [3:0]  devByteSelect_o,
    output logic        active_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_next;
    logic [7:0]    opcode, opcode_next;
    logic [31:0]   shreg, shreg_next, shifted;
    logic [31:0]   addr, addr_next;
    logic [1:0]    byte_cnt, byte_cnt_next;
    logic [TW-1:0] tmo_cnt, tmo_cnt_next;
    logic          bus_req_next, dev_enable_next, dev_write_next;
    logic [31:0]   dev_addr_next, dev_data_next;
    logic [3:0]    byte_sel_next;
    logic          is_write;
    logic          seq_start, seq_wide, seq_done;
    logic [31:0]   seq_word;

    assign shifted  = {rxdData_i, shreg[31:8]};
    assign is_write = (opcode == CMD_WRITE);
    assign active_o = (state != IDLE);

    always_ff @(posedge clk25) begin
        if (rst) begin
            state             <= IDLE;
            opcode            <= '0;
            shreg             <= '0;
            addr              <= '0;
            byte_cnt          <= '0;
            tmo_cnt           <= '0;
            busReq_o          <= 1'b0;
            devEnable_o       <= 1'b0;
            devWrite_o        <= 1'b0;
            devPhysicalAddr_o <= '0;
            devDataSave_o     <= '0;
            devByteSelect_o   <= '0;
        end else begin
            state             <= state_next;
            opcode            <= opcode_next;
            shreg             <= shreg_next;
            addr              <= addr_next;
            byte_cnt          <= byte_cnt_next;
            tmo_cnt           <= tmo_cnt_next;
            busReq_o          <= bus_req_next;
            devEnable_o       <= dev_enable_next;
            devWrite_o        <= dev_write_next;
            devPhysicalAddr_o <= dev_addr_next;
            devDataSave_o     <= dev_data_next;
            devByteSelect_o   <= byte_sel_next;
        end
    end

    always_comb begin
        state_next      = state;
        opcode_next     = opcode;
        shreg_next      = shreg;
        addr_next       = addr;
        byte_cnt_next   = byte_cnt;
        tmo_cnt_next    = tmo_cnt;
        bus_req_next    = busReq_o;
        dev_enable_next = devEnable_o;
        dev_write_next  = devWrite_o;
        dev_addr_next   = devPhysicalAddr_o;
        dev_data_next   = devDataSave_o;
        byte_sel_next   = devByteSelect_o;
        seq_start       = 1'b0;
        seq_word        = {24'h000000, NAK_BYTE};
        seq_wide        = 1'b0;
        case (state)
            IDLE: begin
                tmo_cnt_next = '0;
                if (rxdReady_i) begin
                    if (rxdData_i == CMD_WRITE || rxdData_i == CMD_READ) begin
                        opcode_next   = rxdData_i;
                        byte_cnt_next = '0;
                        state_next    = GET_ADDR;
                    end else begin
                        seq_start  = 1'b1;
                        state_next = TX_LOAD;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                // An arriving byte takes priority over a coincident timeout.
                if (rxdReady_i) begin
                    shreg_next    = shifted;
                    byte_cnt_next = byte_cnt + 2'd1;
                    tmo_cnt_next  = '0;
                    if (byte_cnt == 2'd3) begin
                        if (state == GET_ADDR) begin
                            addr_next = shifted;
                        end
                        if (state == GET_ADDR && is_write) begin
                            state_next = GET_DATA;
                        end else begin
                            state_next   = REQ;
                            bus_req_next = 1'b1;
                        end
                    end
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt + TW'(1);
                end
            end
            REQ: begin
                if (busGrant_i) begin
                    dev_enable_next = 1'b1;
                    dev_write_next  = is_write;
                    dev_addr_next   = addr;
                    dev_data_next   = is_write ? shreg : '0;
                    byte_sel_next   = BYTE_SEL_WORD;
                    state_next      = XFER;
                end
            end
            XFER: begin
                // Read data goes straight into the sequencer, which latches it on start.
                if (!devBusy_i) begin
                    dev_enable_next = 1'b0;
                    dev_write_next  = 1'b0;
                    bus_req_next    = 1'b0;
                    byte_sel_next   = '0;
                    seq_start       = 1'b1;
                    seq_word        = is_write ? {24'h000000, ACK_BYTE} : devDataLoad_i;
                    seq_wide        = !is_write;
                    state_next      = TX_LOAD;
                end
            end
            TX_LOAD: begin
                // TX_START/TX_WAIT are stepped by the sequencer; the top waits here for done.
                if (seq_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    uart_tx_sequencer u_tx_seq (
        .clk25     (clk25),
        .rst       (rst),
        .start     (seq_start),
        .word      (seq_word),
        .wide      (seq_wide),
        .txd_busy  (txdBusy_i),
        .txd_start (txdStart_o),
        .txd_data  (txdData_o),
        .done      (seq_done)
    );

endmodule

// File: tb/tb_uart_dev_bridge.sv
// Scoreboard bench for uart_dev_bridge: expected bus transactions and reply bytes
// are queued with each command and checked as the bridge produces them.
module tb_uart_dev_bridge;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        rxdReady_i = 1'b0;
    logic [7:0]  rxdData_i = '0;
    logic        txdBusy_i = 1'b0;
    logic        txdStart_o;
    logic [7:0]  txdData_o;
    logic        busReq_o;
    logic        busGrant_i = 1'b0;
    logic        devEnable_o;
    logic        devWrite_o;
    logic        devBusy_i = 1'b0;
    logic [31:0] devPhysicalAddr_o;
    logic [31:0] devDataSave_o;
    logic [31:0] devDataLoad_i = '0;
    logic [3:0]  devByteSelect_o;
    logic        active_o;

    uart_dev_bridge #(
        .TIMEOUT_CYCLES (100),
        .ACK_BYTE       (8'h4B),
        .NAK_BYTE       (8'h3F)
    ) dut (
        .clk25             (clk25),
        .rst               (rst),
        .rxdReady_i        (rxdReady_i),
        .rxdData_i         (rxdData_i),
        .txdBusy_i         (txdBusy_i),
        .txdStart_o        (txdStart_o),
        .txdData_o         (txdData_o),
        .busReq_o          (busReq_o),
        .busGrant_i        (busGrant_i),
        .devEnable_o       (devEnable_o),
        .devWrite_o        (devWrite_o),
        .devBusy_i         (devBusy_i),
        .devPhysicalAddr_o (devPhysicalAddr_o),
        .devDataSave_o     (devDataSave_o),
        .devDataLoad_i     (devDataLoad_i),
        .devByteSelect_o   (devByteSelect_o),
        .active_o          (active_o)
    );

    always #20 clk25 = ~clk25;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
        int unsigned en_cycles;
    } bus_exp_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [7:0]  tx_q[$];
    bus_exp_t    bus_q[$];
    int unsigned slave_wait  = 0;
    int unsigned grant_delay = 0;
    int unsigned bus_done    = 0;
    int unsigned tx_seen     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Models of the transmitter, the bus slave and the arbiter, plus output checking.
    initial begin
        int unsigned txd_left = 0;
        int unsigned k = 0;
        int unsigned gwait = 0;
        logic        en_in_wait = 1'b0;
        bus_exp_t    cur;
        logic [7:0]  exp_b;
        cur = '{addr: '0, data: '0, write: 1'b0, en_cycles: 0};
        forever begin
            @(negedge clk25);
            if (rst) begin
                txd_left = 0; k = 0; gwait = 0; en_in_wait = 1'b0;
                txdBusy_i = 1'b0; devBusy_i = 1'b0; busGrant_i = 1'b0;
            end else begin
                if (txdStart_o) begin
                    tx_seen++;
                    if (tx_q.size() == 0) begin
                        check("tx_unexpected", 1, 0);
                    end else begin
                        exp_b = tx_q.pop_front();
                        check("tx_byte", {24'h0, txdData_o}, {24'h0, exp_b});
                    end
                    txd_left = 8;
                end else if (txd_left > 0) begin
                    txd_left--;
                end
                txdBusy_i = (txd_left > 0);

                if (devEnable_o) begin
                    k++;
                    devBusy_i = (k <= slave_wait);
                    if (!devBusy_i) begin
                        bus_done++;
                        if (bus_q.size() == 0) begin
                            check("bus_unexpected", 1, 0);
                        end else begin
                            cur = bus_q.pop_front();
                            check("bus_addr", devPhysicalAddr_o, cur.addr);
                            check("bus_write", {31'h0, devWrite_o}, {31'h0, cur.write});
                            check("bus_bsel", {28'h0, devByteSelect_o}, 32'hF);
                            check("bus_req_held", {31'h0, busReq_o}, 1);
                            if (cur.write) check("bus_wdata", devDataSave_o, cur.data);
                        end
                    end
                end else begin
                    if (k > 0) begin
                        check("bus_en_cycles", k, cur.en_cycles);
                        check("bus_req_drop", {31'h0, busReq_o}, 0);
                        check("bus_write_drop", {31'h0, devWrite_o}, 0);
                    end
                    k = 0;
                    devBusy_i = 1'b0;
                end

                if (busReq_o && !busGrant_i) begin
                    if (devEnable_o) en_in_wait = 1'b1;
                    if (gwait >= grant_delay) begin
                        if (grant_delay > 0) check("grant_wait_en", {31'h0, en_in_wait}, 0);
                        busGrant_i = 1'b1;
                        gwait = 0;
                        en_in_wait = 1'b0;
                    end else begin
                        gwait++;
                    end
                end else if (!busReq_o) begin
                    busGrant_i = 1'b0;
                    gwait = 0;
                    en_in_wait = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk25);
        rxdData_i  = b;
        rxdReady_i = 1'b1;
        @(negedge clk25);
        rxdReady_i = 1'b0;
        repeat (2) @(negedge clk25);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic push_read(input logic [31:0] a, input logic [31:0] d, input int unsigned en);
        bus_q.push_back('{addr: a, data: '0, write: 1'b0, en_cycles: en});
        for (int i = 0; i < 4; i++) tx_q.push_back(d[8*i +: 8]);
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while ((active_o || tx_q.size() != 0 || bus_q.size() != 0) && n < 3000) begin
            @(negedge clk25);
            n++;
        end
        check({tag, "_in_time"}, {31'h0, (n < 3000)}, 1);
        check({tag, "_tx_left"}, tx_q.size(), 0);
        check({tag, "_bus_left"}, bus_q.size(), 0);
        tx_q.delete();
        bus_q.delete();
        repeat (4) @(negedge clk25);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txd"}, {23'h0, txdStart_o, txdData_o}, 0);
        check({tag, "_ctrl"}, {28'h0, busReq_o, devEnable_o, devWrite_o, active_o}, 0);
        check({tag, "_addr"}, devPhysicalAddr_o, 0);
        check({tag, "_wdata"}, devDataSave_o, 0);
        check({tag, "_bsel"}, {28'h0, devByteSelect_o}, 0);
    endtask

    initial begin
        int unsigned snap;
        int unsigned n;

        repeat (3) @(negedge clk25);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk25);

        // Write with immediate grant and zero-wait slave
        slave_wait = 0; grant_delay = 0;
        bus_q.push_back('{addr: 32'h8000_0000, data: 32'hDEAD_BEEF, write: 1'b1, en_cycles: 1});
        tx_q.push_back(8'h4B);
        send_byte(8'h57);
        send_word(32'h8000_0000);
        send_word(32'hDEAD_BEEF);
        wait_done("write");

        // Read with a 3-cycle busy slave
        slave_wait = 3; devDataLoad_i = 32'h1234_5678;
        push_read(32'h8000_0004, 32'h1234_5678, 4);
        send_byte(8'h52);
        send_word(32'h8000_0004);
        wait_done("read");

        // Grant withheld for 50 cycles
        slave_wait = 0; grant_delay = 50; devDataLoad_i = 32'hCAFE_F00D;
        push_read(32'h8000_0010, 32'hCAFE_F00D, 1);
        send_byte(8'h52);
        send_word(32'h8000_0010);
        wait_done("grant");
        grant_delay = 0;

        // Unknown opcode, then a valid write
        snap = bus_done;
        tx_q.push_back(8'h3F);
        send_byte(8'h41);
        wait_done("nak");
        check("nak_no_bus", bus_done, snap);
        bus_q.push_back('{addr: 32'h8000_0010, data: 32'h4433_2211, write: 1'b1, en_cycles: 1});
        tx_q.push_back(8'h4B);
        send_byte(8'h57);
        send_word(32'h8000_0010);
        send_word(32'h4433_2211);
        wait_done("after_nak");

        // Inter-byte timeout aborts silently, following read executes
        snap = tx_seen;
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (101) @(negedge clk25);
        check("timeout_idle", {31'h0, active_o}, 0);
        check("timeout_silent", tx_seen, snap);
        devDataLoad_i = 32'hA5A5_5A5A;
        push_read(32'h8000_0000, 32'hA5A5_5A5A, 1);
        send_byte(8'h52);
        send_word(32'h8000_0000);
        wait_done("timeout_read");

        // Reset while a read is stalled in XFER
        slave_wait = 20;
        snap = tx_seen;
        send_byte(8'h52);
        send_word(32'h8000_0000);
        n = 0;
        while (!devEnable_o && n < 200) begin
            @(negedge clk25);
            n++;
        end
        check("rst_reached_xfer", {31'h0, devEnable_o}, 1);
        rst = 1'b1;
        @(negedge clk25);
        check_reset_outputs("rst_mid");
        @(negedge clk25);
        rst = 1'b0;
        repeat (40) @(negedge clk25);
        check("rst_mid_no_reply", tx_seen, snap);
        check("rst_mid_idle", {31'h0, active_o}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
